// File: rtl/draw_scheduler.sv
// Per-frame draw sequencer: grants the VGA pixel port to enabled clients in index order
// and registers the granted client's pixel. Optional watchdog under DRAW_WATCHDOG_EN.
module draw_scheduler #(
  parameter int unsigned NCLI    = 4,
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 7,
  parameter int unsigned CW      = 3,
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic [NCLI-1:0]    client_mask,
  input  logic [NCLI-1:0]    cli_done,
  input  logic [NCLI*XW-1:0] cli_x,
  input  logic [NCLI*YW-1:0] cli_y,
  input  logic [NCLI*CW-1:0] cli_colour,
  output logic [NCLI-1:0]    cli_en,
  output logic [XW-1:0]      vga_x,
  output logic [YW-1:0]      vga_y,
  output logic [CW-1:0]      vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic               timeout_err
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP, DONE} state_t;

  state_t          state, state_n;
  logic [2:0]      idx, idx_n;
  logic [NCLI-1:0] mask_q, mask_n;
  logic            done_sel;
  logic            wd_fire;
  logic [XW-1:0]   x_sel;
  logic [YW-1:0]   y_sel;
  logic [CW-1:0]   c_sel;

  function automatic logic [2:0] lowest(input logic [NCLI-1:0] m);
    logic [2:0] r;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      if (m[i] && !found) begin
        r     = 3'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Grant decode and pixel mux both key off the registered idx only.
  always_comb begin
    cli_en = '0;
    x_sel  = '0;
    y_sel  = '0;
    c_sel  = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      if (idx == 3'(i)) begin
        x_sel     = cli_x[i*XW +: XW];
        y_sel     = cli_y[i*YW +: YW];
        c_sel     = cli_colour[i*CW +: CW];
        cli_en[i] = (state == GRANT);
      end
    end
  end

  assign done_sel   = |(cli_done & cli_en);
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

`ifdef DRAW_WATCHDOG_EN
  logic [15:0] wd_cnt;
  assign wd_fire = (state == GRANT) && !done_sel && (wd_cnt == TIMEOUT - 16'd1);
`else
  logic unused_timeout;
  assign wd_fire        = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    mask_n  = mask_q;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          mask_n = client_mask;
          if (client_mask == '0) begin
            state_n = DONE;
          end else begin
            idx_n   = lowest(client_mask);
            state_n = GRANT;
          end
        end
      end
      GRANT: begin
        if (done_sel || wd_fire) begin
          mask_n  = mask_q & ~cli_en;
          state_n = GAP;
        end
      end
      GAP: begin
        if (mask_q != '0) begin
          idx_n   = lowest(mask_q);
          state_n = GRANT;
        end else begin
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      idx        <= '0;
      mask_q     <= '0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      mask_q     <= mask_n;
      vga_plot   <= (state == GRANT);
      vga_x      <= x_sel;
      vga_y      <= y_sel;
      vga_colour <= c_sel;
      if (frame_tick && state != IDLE) overrun <= 1'b1;
    end
  end

`ifdef DRAW_WATCHDOG_EN
  // Counter sits at zero outside GRANT, so every grant starts counting from zero.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      wd_cnt <= (state == GRANT) ? wd_cnt + 16'd1 : '0;
      if (wd_fire) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler: client models, timeline model and pixel scoreboard.
module tb_draw_scheduler;
  localparam int unsigned NCLI = 4;
  localparam int unsigned XW   = 8;
  localparam int unsigned YW   = 7;
  localparam int unsigned CW   = 3;
`ifdef DRAW_WATCHDOG_EN
  localparam int WD = 8;
`else
  localparam int WD = 0;
`endif

  logic               clk;
  logic               resetn;
  logic               frame_tick;
  logic [NCLI-1:0]    client_mask;
  logic [NCLI-1:0]    cli_done;
  logic [NCLI*XW-1:0] cli_x;
  logic [NCLI*YW-1:0] cli_y;
  logic [NCLI*CW-1:0] cli_colour;
  logic [NCLI-1:0]    cli_en;
  logic [XW-1:0]      vga_x;
  logic [YW-1:0]      vga_y;
  logic [CW-1:0]      vga_colour;
  logic               vga_plot, busy, frame_done, overrun, timeout_err;

  draw_scheduler #(.NCLI(NCLI), .XW(XW), .YW(YW), .CW(CW), .TIMEOUT(16'd8)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .client_mask(client_mask),
    .cli_done(cli_done), .cli_x(cli_x), .cli_y(cli_y), .cli_colour(cli_colour),
    .cli_en(cli_en), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int              ncmp = 0;
  int              nfail = 0;
  logic [17:0]     sbq[$];
  int              len[NCLI];
  int              cnt[NCLI];
  logic [NCLI-1:0] prev_en = '0;
  logic [NCLI-1:0] stray = '0;
  bit              ov_exp = 0;
  bit              to_exp = 0;

  function automatic logic [17:0] pix(input int i, input int k);
    return {8'(i * 40 + k), 7'(i * 20 + k), 3'(i + k)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_clients();
    logic [17:0] p;
    for (int unsigned i = 0; i < NCLI; i++) begin
      p = pix(int'(i), cnt[i]);
      cli_x[i*XW +: XW]      = p[17:10];
      cli_y[i*YW +: YW]      = p[9:3];
      cli_colour[i*CW +: CW] = p[2:0];
      cli_done[i] = (cli_en[i] && cnt[i] == len[i] - 1) || stray[i];
    end
  endtask

  // Advance one cycle; client counters clear while their enable is low.
  task automatic cyc();
    logic [17:0] e;
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < NCLI; i++) cnt[i] = prev_en[i] ? cnt[i] + 1 : 0;
    prev_en = cli_en;
    drive_clients();
    if (vga_plot === 1'b1) begin
      if (sbq.size() == 0) chk("plot_unexpected", 32'(vga_plot), 0);
      else begin
        e = sbq.pop_front();
        chk("pixel", {vga_x, vga_y, vga_colour}, e);
      end
    end
  endtask

  // t2: cycle of an extra tick (-1 none); rst_at: cycle holding resetn low (-1 none).
  task automatic frame(input logic [NCLI-1:0] mask, input int t2, input int rst_at);
    logic [NCLI-1:0] ee[$];
    bit              tg[$];
    int              eff, done_c;
    logic [NCLI-1:0] e_en;
    bit              e_plot;
    for (int unsigned i = 0; i < NCLI; i++) begin
      if (mask[i]) begin
        eff = (WD != 0 && len[i] > WD) ? WD : len[i];
        for (int k = 0; k < eff; k++) begin
          ee.push_back(NCLI'(1) << i);
          tg.push_back(0);
          sbq.push_back(pix(int'(i), k));
        end
        ee.push_back('0);
        tg.push_back(eff < len[i]);
      end
    end
    done_c = ee.size() + 1;
    client_mask = mask;
    frame_tick  = 1'b1;
    cyc();
    frame_tick  = 1'b0;
    client_mask = NCLI'($urandom);
    for (int c = 1; c <= done_c + 3; c++) begin
      e_en = '0;
      if (c - 1 < ee.size()) begin
        e_en = ee[c-1];
        if (tg[c-1]) to_exp = 1;
      end
      e_plot = (c >= 2) && (c - 2 < ee.size()) && (ee[c-2] != '0);
      chk("cli_en", 32'(cli_en), 32'(e_en));
      chk("frame_done", 32'(frame_done), 32'(c == done_c));
      chk("vga_plot", 32'(vga_plot), 32'(e_plot));
      chk("busy", 32'(busy), 32'(c <= done_c));
      chk("overrun", 32'(overrun), 32'(ov_exp));
      chk("timeout_err", 32'(timeout_err), 32'(to_exp));
      if (c == t2) frame_tick = 1'b1;
      if (c == rst_at) resetn = 1'b0;
      cyc();
      frame_tick = 1'b0;
      if (c == t2) ov_exp = 1;
      if (c == rst_at) begin
        resetn = 1'b1;
        ov_exp = 0;
        to_exp = 0;
        sbq.delete();
        for (int r = 0; r < 3; r++) begin
          chk("rst_cli_en", 32'(cli_en), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_frame_done", 32'(frame_done), 0);
          chk("rst_vga_plot", 32'(vga_plot), 0);
          chk("rst_overrun", 32'(overrun), 0);
          cyc();
        end
        return;
      end
    end
    chk("sb_empty", 32'(sbq.size()), 0);
  endtask

  initial begin
    resetn      = 1'b0;
    frame_tick  = 1'b0;
    client_mask = '0;
    cli_done    = '0;
    cli_x       = '0;
    cli_y       = '0;
    cli_colour  = '0;
    for (int unsigned i = 0; i < NCLI; i++) begin
      cnt[i] = 0;
      len[i] = 4;
    end

    for (int r = 0; r < 3; r++) begin
      frame_tick  = 1'($urandom);
      client_mask = NCLI'($urandom);
      cyc();
      chk("reset_cli_en", 32'(cli_en), 0);
      chk("reset_vga_plot", 32'(vga_plot), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_frame_done", 32'(frame_done), 0);
      chk("reset_overrun", 32'(overrun), 0);
      chk("reset_timeout_err", 32'(timeout_err), 0);
    end
    resetn     = 1'b1;
    frame_tick = 1'b0;
    cyc();

`ifdef DRAW_WATCHDOG_EN
    len[0] = 8;
    frame(4'b0001, -1, -1);
    len[0] = 1000;
    len[1] = 3;
    frame(4'b0011, -1, -1);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    ov_exp = 0;
    to_exp = 0;
    chk("wd_reset_err", 32'(timeout_err), 0);
`endif

    len[0] = 10; len[1] = 3; len[2] = 5; len[3] = 1;
    stray = 4'b0010;
    frame(4'b0101, -1, -1);
    stray = '0;
    frame(4'b0101, 5, -1);
    frame(4'b0101, -1, 4);
    frame(4'b0101, -1, -1);
    frame(4'b0000, 1, -1);
    frame(4'b1000, -1, -1);
    frame(4'b1111, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Per-frame draw sequencer and plotter arbiter for the VGA writer.
- On each frame tick it grants the single VGA pixel port to the enabled drawing clients one at a time, lowest index first. Clients are the map drawer, tank drawers and bullet drawers.
- Each client is an enable/finish-style drawer whose counters clear while its enable is low.
- The scheduler muxes the granted client's coordinates and colour onto a registered plot bus, and reports frame completion and overrun.

Parameters:
- NCLI, 4, number of drawing clients (1..8).
- XW, 8, x coordinate width.
- YW, 7, y coordinate width.
- CW, 3, colour width.
- TIMEOUT, 16'd20000, per-grant watchdog limit in cycles; used only with DRAW_WATCHDOG_EN.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse requesting a frame redraw.
- client_mask  in  NCLI  clients to draw this frame; sampled only on an accepted frame_tick.
- cli_done  in  NCLI  client i finished (its last pixel is valid in the same cycle).
- cli_x  in  NCLI*XW  client i x at [i*XW +: XW].
- cli_y  in  NCLI*YW  client i y at [i*YW +: YW].
- cli_colour  in  NCLI*CW  client i colour at [i*CW +: CW].
- cli_en  out  NCLI  one-hot grant/enable, or all zero.
- vga_x  out  XW  registered plot x.
- vga_y  out  YW  registered plot y.
- vga_colour  out  CW  registered plot colour.
- vga_plot  out  1  registered plot strobe.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the frame completes.
- overrun  out  1  sticky: frame_tick arrived while busy.
- timeout_err  out  1  sticky watchdog flag (tied 0 without the macro).

Behaviour:
- Reset: resetn sampled low at a clk edge forces state=IDLE. All outputs, mask_q, idx and the watchdog counter go to 0. This applies mid-grant too: cli_en drops at that edge, with no completion pulse.
- States: IDLE, GRANT, GAP, DONE. State and idx are registered; cli_en = (state==GRANT) ? (1<<idx) : 0, decoded from registers only.
- IDLE, frame_tick=1:
  - mask_q <= client_mask.
  - If client_mask==0, go to DONE.
  - Otherwise idx <= lowest set bit of client_mask and go to GRANT.
- GRANT:
  - cli_en[idx]=1.
  - If cli_done[idx]=1: clear mask_q[idx] and go to GAP.
  - cli_done bits of non-granted clients are ignored in every state.
- GAP:
  - Exactly one cycle with cli_en=0, so the finished client's counters clear.
  - If the remaining mask_q is nonzero, idx <= its lowest set bit and go to GRANT. Otherwise go to DONE.
  - cli_done is ignored.
- DONE: frame_done=1 for this single cycle, then go to IDLE.
- frame_tick while state!=IDLE:
  - Ignored; does not restart the frame and does not queue a redraw.
  - Sets overrun=1, which holds until reset.
  - frame_tick in the same cycle as the DONE state also counts as overrun.
- Plot pipeline, latency 1 cycle:
  - Each cycle: vga_plot <= (state==GRANT); vga_x/vga_y/vga_colour <= slice idx of cli_x/cli_y/cli_colour.
  - The done cycle's pixel is plotted. GAP, IDLE and DONE cycles produce vga_plot=0.
  - When vga_plot=0, coordinates may hold any value.
- Widths: idx is 3 bits. Slices use the indexed part-select; out-of-range idx (>=NCLI) is unreachable.

Optional Feature:
- Macro: DRAW_WATCHDOG_EN.
- Defined:
  - A 16-bit counter clears on entry to GRANT and increments each GRANT cycle.
  - If the count reaches TIMEOUT-1 with cli_done[idx]=0, the scheduler takes the same action as done: clear the bit, go to GAP.
  - It also sets timeout_err=1, sticky until reset.
  - A genuine done in that same cycle takes priority, and timeout_err is not set.
- Undefined: no counter; GRANT waits indefinitely; timeout_err is constant 0.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with random inputs -> cli_en=0, vga_plot=0, busy=0, frame_done=0, overrun=0, timeout_err=0.
- Two-client sequencing:
  - Stimulus: client_mask=4'b0101, tick at cycle 0; client0 asserts done on its 10th enabled cycle; client2 asserts done on its 5th enabled cycle.
  - Response: cli_en=0001 for cycles 1..10; cycle 11 is a GAP with cli_en=0; cli_en=0100 for cycles 12..16; cycle 17 is a GAP; frame_done=1 in cycle 18 only.
  - vga_plot is high in cycles 2..11 and 13..17.
- Empty mask: client_mask=0, tick at cycle 0 -> frame_done=1 in cycle 1, cli_en stays 0, vga_plot stays 0.
- Overrun: tick again at cycle 5 during the scenario above -> overrun=1 from cycle 6, the sequence is unchanged, and no second frame starts.
- Mid-grant reset: resetn=0 at cycle 4 of a grant -> cli_en=0 and busy=0 after that edge, no frame_done; a fresh tick afterward restarts from the lowest-index client.
- Watchdog (macro on, TIMEOUT=8): client0 never asserts done -> cli_en[0] is high for exactly 8 cycles, then a GAP, then the next client is granted; timeout_err=1 stays latched.
